acc_op_unit: RTL
================

// Module: acc_op_unit
// PURPOSE
//  Operand/execute stage directly upstream of the accumulator register.
//  Takes the current accumulator value, an operand and an opcode, computes the result.
//  Drives the accumulator's write-enable and data input via out_data/wr_acc.
//  Single-cycle ops finish in 1 cycle; MUL is an iterative shift-add over WIDTH cycles.
// PARAMETERS
//  WIDTH    16   data width of acc_q, operand, out_data
//  OPW      3    opcode width
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      one-cycle request; sampled only in IDLE
//  op        in   OPW    opcode, sampled with start
//  acc_q     in   WIDTH  current accumulator value, sampled with start
//  operand   in   WIDTH  second operand (immediate or memory data), sampled with start
//  out_data  out  WIDTH  result -> accumulator data input
//  wr_acc    out  1      one-cycle accumulator write-enable, aligned with out_data
//  busy      out  1      high from the cycle after an accepted start until done
//  done      out  1      one-cycle completion pulse; NOP gives done without wr_acc
//  ovf       out  1      signed overflow of ADD/SUB, or MUL product exceeding WIDTH bits
// BEHAVIOUR
//  Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
//  Reset: FSM=IDLE; out_data=0; wr_acc=0; busy=0; done=0; ovf=0; internal regs cleared.
//  Opcodes: 000 LD  res=operand        001 ADD res=acc_q+operand
//           010 SUB res=acc_q-operand  011 MUL res=low WIDTH bits of acc_q*operand
//           100 AND  101 OR  110 XOR   111 NOP (no write)
//  Arithmetic: unsigned modulo 2^WIDTH.
//   ovf for ADD/SUB = two's-complement signed overflow.
//   ovf for MUL = OR of high WIDTH product bits. ovf=0 for logic ops and LD.
//   ovf is registered and held until the next done.
//  FSM: IDLE, EXEC, MUL, DONE.
//   IDLE: start=1 -> latch op/acc_q/operand.
//         op==MUL -> MUL with cnt=0; otherwise -> EXEC.
//   EXEC: compute result -> DONE.
//   MUL: each cycle, if mplier[0] add mcand into the 2*WIDTH product.
//        Shift mcand left and mplier right; cnt++.
//        cnt==WIDTH-1 -> DONE.
//   DONE: out_data=res; wr_acc=1 (0 for NOP); done=1; ovf updated -> IDLE.
//  Latency from start cycle N:
//   non-MUL: wr_acc/done high in cycle N+2.
//   MUL: wr_acc/done high in cycle N+WIDTH+2.
//  busy: high for cycles N+1 .. done cycle inclusive; low in IDLE.
//  wr_acc/done: single-cycle pulses, deasserted in all other cycles.
//   out_data holds its last value between writes.
//  Handshake: start while busy is ignored and not queued.
//   start in the same cycle done is high is also ignored, because the FSM is not yet in IDLE.
//  acc_q/operand changes after the start cycle have no effect (operands latched).
//  Reset mid-operation: asserting rst_n=0 aborts immediately.
//   Outputs go to reset values asynchronously; no wr_acc is issued.
//  Unknown op: not possible with OPW=3; 111 is NOP by definition.
// STRUCTURE
//  Shared package acc_pkg: opcode localparams (OP_LD..OP_NOP), FSM state encoding,
//   WIDTH default.
//  One sub-module: seq_mult (WIDTH-cycle shift-add multiplier with start/done).
//   The top FSM waits on it in state MUL.
//  The add/sub/logic result mux stays in the top level; no further hierarchy.
// TESTING
//  Reset: rst_n=0 mid-MUL at cycle 5 -> all outputs 0 immediately.
//   After release, FSM idle; no wr_acc pulse.
//  ADD: acc_q=0x7FFF, operand=0x0001, start -> cycle N+2: out_data=0x8000, wr_acc=1, done=1, ovf=1.
//  SUB wrap: acc_q=0x0000, operand=0x0001 -> out_data=0xFFFF, ovf=0.
//   LD 0x1234 -> out_data=0x1234.
//  MUL: 0x0012*0x0034 -> out_data=0x03A8, ovf=0 at N+18.
//   0x0100*0x0100 -> out_data=0x0000, ovf=1.
//  Busy collision: start MUL, re-pulse start with ADD at N+3 -> ignored.
//   Exactly one done; result is the MUL result.
//  NOP: start op=111 -> done=1 at N+2 with wr_acc=0; out_data keeps its previous value.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared opcodes, FSM encoding and default width for the accumulator
// operand/execute stage.
package acc_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_OPW   = 3;

    localparam logic [2:0] OP_LD  = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_e;

endpackage

// File: rtl/acc_op_unit_seq_mult.sv
// Iterative shift-add multiplier: one partial product per cycle,
// full 2*W product valid with a one-cycle done_o pulse.
module seq_mult #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [W-1:0]   mcand_i,
    input  logic [W-1:0]   mplier_i,
    output logic           done_o,
    output logic [2*W-1:0] prod_o
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] prod_q;
    logic [CW-1:0]  cnt_q;
    logic           run_q;
    logic           done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{W{1'b0}}, mcand_i};
            mplier_q <= mplier_i;
            prod_q   <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (run_q) begin
                if (mplier_q[0]) begin
                    prod_q <= prod_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                // last partial product lands together with done
                if (cnt_q == CW'(W - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign prod_o = prod_q;

endmodule

// File: rtl/acc_op_unit.sv
// Operand/execute stage feeding the accumulator: single-cycle ALU ops
// plus a WIDTH-cycle multiply, with registered write-back outputs.
module acc_op_unit
    import acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] acc_q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] out_data,
    output logic             wr_acc,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    state_e             state_q, state_d;
    logic [OPW-1:0]     op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               wr_q, wr_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;

    seq_mult #(
        .W(WIDTH)
    ) u_mult (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (mul_start),
        .mcand_i  (acc_q),
        .mplier_i (operand),
        .done_o   (mul_done),
        .prod_o   (mul_prod)
    );

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op_q)
            OP_LD:  alu_res = b_q;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        out_d     = out_q;
        wr_d      = 1'b0;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = op;
                    a_d  = acc_q;
                    b_d  = operand;
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                ovf_d   = alu_ovf;
                if (op_q != OP_NOP) begin
                    wr_d  = 1'b1;
                    out_d = alu_res;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    wr_d    = 1'b1;
                    out_d   = mul_prod[WIDTH-1:0];
                    ovf_d   = |mul_prod[2*WIDTH-1:WIDTH];
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data = out_q;
    assign wr_acc   = wr_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign busy     = (state_q != S_IDLE);

endmodule
